// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// Holds the FSM state, pattern mode and bounce direction encodings.
package led_seq_pkg;

    localparam int unsigned LED_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} seq_state_t;
    typedef enum logic [1:0] {BLINK, CHASE, BOUNCE, COUNT} seq_mode_t;
    typedef enum logic {LEFT, RIGHT} dir_t;

    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable tick prescaler: strobes adv when the count reaches (PERIOD >> speed) - 1.
// The count holds while disabled and is forced to zero by clear.
module tick_prescaler #(
    parameter int unsigned PERIOD = 6_750_000,
    parameter int unsigned W_DIV  = $clog2(PERIOD)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       adv
);

    logic [W_DIV-1:0] div_q, div_d;
    logic [W_DIV-1:0] term;
    logic             at_term;

    // >= rather than == so a speed change that leaves the count past the new
    // terminal value wraps immediately instead of running the counter around.
    always_comb begin
        term    = W_DIV'((PERIOD >> speed) - 1);
        at_term = (div_q >= term);
        adv     = enable && at_term;
        div_d   = div_q;
        if (clear) begin
            div_d = '0;
        end else if (enable) begin
            div_d = at_term ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Run/pause/step sequencer driving 8 LEDs through BLINK, CHASE, BOUNCE and COUNT patterns.
// The pattern register advances on prescaler terminal count in RUN or on step in PAUSE.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned PERIOD = 6_750_000,
    parameter int unsigned W_DIV  = $clog2(PERIOD)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    output logic [7:0] led,
    output logic       tick,
    output logic       running
);

    seq_state_t       state_q, state_d;
    logic [LED_W-1:0] pat_q, pat_d;
    dir_t             dir_q, dir_d;
    logic             tick_q;
    logic             pre_en, pre_clr, pre_adv;
    logic             step_adv, advance;

    tick_prescaler #(
        .PERIOD(PERIOD),
        .W_DIV (W_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .enable(pre_en),
        .clear (pre_clr),
        .speed (speed),
        .adv   (pre_adv)
    );

    // A stop in RUN freezes the prescaler on that edge so the held count is
    // exactly what resumes later.
    always_comb begin
        state_d  = state_q;
        pre_en   = 1'b0;
        step_adv = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (stop) state_d = PAUSE;
                else      pre_en  = 1'b1;
            end
            PAUSE: begin
                if (stop)       state_d  = IDLE;
                else if (start) state_d  = RUN;
                else if (step)  step_adv = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        pre_clr = (state_q == IDLE);
        advance = (pre_en && pre_adv) || step_adv;
    end

    always_comb begin
        pat_d = pat_q;
        dir_d = dir_q;
        if (state_d == IDLE) begin
            pat_d = '0;
            dir_d = LEFT;
        end else if (advance) begin
            unique case (seq_mode_t'(mode))
                BLINK: pat_d = ~pat_q;
                CHASE: pat_d = is_onehot(pat_q) ? {pat_q[LED_W-2:0], pat_q[LED_W-1]}
                                                : LED_W'(1);
                BOUNCE: begin
                    if (!is_onehot(pat_q)) begin
                        pat_d = LED_W'(1);
                        dir_d = LEFT;
                    end else if (pat_q == 8'h80) begin
                        pat_d = 8'h40;
                        dir_d = RIGHT;
                    end else if (pat_q == 8'h01 && dir_q == RIGHT) begin
                        pat_d = 8'h02;
                        dir_d = LEFT;
                    end else if (dir_q == LEFT) begin
                        pat_d = pat_q << 1;
                    end else begin
                        pat_d = pat_q >> 1;
                    end
                end
                COUNT: pat_d = pat_q + 1'b1;
                default: pat_d = pat_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            dir_q   <= LEFT;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            tick_q  <= advance;
        end
    end

    assign led     = pat_q;
    assign tick    = tick_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with PERIOD=16; inputs change and outputs
// are sampled on the falling edge.
module tb_led_pattern_sequencer;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       step;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [7:0] led;
    logic       tick;
    logic       running;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] bounce_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    led_pattern_sequencer #(
        .PERIOD(16)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .step   (step),
        .mode   (mode),
        .speed  (speed),
        .led    (led),
        .tick   (tick),
        .running(running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_led, input logic e_tick,
                             input logic e_run);
        check_eq({tag, ".led"}, 32'(led), 32'(e_led));
        check_eq({tag, ".tick"}, 32'(tick), 32'(e_tick));
        check_eq({tag, ".running"}, 32'(running), 32'(e_run));
    endtask

    // Called on a falling edge; drives a one-cycle pulse and returns on the next falling edge.
    task automatic cmd(input logic s, input logic p, input logic t);
        start = s;
        stop  = p;
        step  = t;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [7:0] e;
        reset = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        step  = 1'b0;
        mode  = 2'd0;
        speed = 2'd0;

        // Reset with start held
        @(negedge clock);
        check_out("rst0", 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        check_out("rst1", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check_out("rst_rel", 8'h00, 1'b0, 1'b0);

        // COUNT at speed 0: 16-cycle spacing
        mode  = 2'd3;
        speed = 2'd0;
        cmd(1'b1, 1'b0, 1'b0);
        check_out("cnt_entry", 8'h00, 1'b0, 1'b1);
        wait_n(15);
        check_out("cnt_pre1", 8'h00, 1'b0, 1'b1);
        wait_n(1);
        check_out("cnt_1", 8'h01, 1'b1, 1'b1);
        wait_n(1);
        check_out("cnt_1b", 8'h01, 1'b0, 1'b1);
        wait_n(15);
        check_out("cnt_2", 8'h02, 1'b1, 1'b1);
        wait_n(16);
        check_out("cnt_3", 8'h03, 1'b1, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);
        check_out("cnt_pause", 8'h03, 1'b0, 1'b0);
        repeat (252) cmd(1'b0, 1'b0, 1'b1);
        check_out("cnt_ff", 8'hFF, 1'b1, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        check_out("cnt_wrap", 8'h00, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        check_out("cnt_idle", 8'h00, 1'b0, 1'b0);

        // CHASE at speed 3: advance every 2 cycles
        mode  = 2'd1;
        speed = 2'd3;
        cmd(1'b1, 1'b0, 1'b0);
        wait_n(2);
        check_out("chase_0", 8'h01, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            wait_n(2);
            e = 8'h01 << (i % 8);
            check_eq("chase_led", 32'(led), 32'(e));
        end
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        check_out("chase_idle", 8'h00, 1'b0, 1'b0);

        // Speed raised while count is 9: wraps on the next edge
        speed = 2'd0;
        cmd(1'b1, 1'b0, 1'b0);
        wait_n(9);
        check_out("spd_pre", 8'h00, 1'b0, 1'b1);
        speed = 2'd3;
        wait_n(1);
        check_out("spd_wrap", 8'h01, 1'b1, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);

        // BOUNCE for 16 advances
        mode  = 2'd2;
        speed = 2'd3;
        cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            wait_n(2);
            check_eq("bounce_led", 32'(led), 32'(bounce_exp[i]));
        end
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);

        // BLINK to 0xFF, then BOUNCE recovers to 0x01
        mode = 2'd0;
        cmd(1'b1, 1'b0, 1'b0);
        wait_n(2);
        check_out("blink_ff", 8'hFF, 1'b1, 1'b1);
        mode = 2'd2;
        wait_n(2);
        check_out("bounce_fix", 8'h01, 1'b1, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);

        // Pause, two steps, resume from held count 5
        mode  = 2'd3;
        speed = 2'd0;
        cmd(1'b1, 1'b0, 1'b0);
        wait_n(5);
        cmd(1'b0, 1'b1, 1'b0);
        check_out("p_pause", 8'h00, 1'b0, 1'b0);
        wait_n(3);
        check_out("p_frozen", 8'h00, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        check_out("p_step1", 8'h01, 1'b1, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        check_out("p_step2", 8'h02, 1'b1, 1'b0);
        wait_n(1);
        check_out("p_after", 8'h02, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        check_out("p_resume", 8'h02, 1'b0, 1'b1);
        wait_n(10);
        check_out("p_res_pre", 8'h02, 1'b0, 1'b1);
        wait_n(1);
        check_out("p_res_adv", 8'h03, 1'b1, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);
        check_out("p_pause2", 8'h03, 1'b0, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        check_out("p_idle", 8'h00, 1'b0, 1'b0);

        // start+stop together in RUN goes to PAUSE
        cmd(1'b1, 1'b0, 1'b0);
        cmd(1'b1, 1'b1, 1'b0);
        check_out("ss_run", 8'h00, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        check_out("ss_step", 8'h01, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        check_out("ss_idle", 8'h00, 1'b0, 1'b0);

        // step in RUN is ignored
        speed = 2'd3;
        cmd(1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        check_out("runstep", 8'h00, 1'b0, 1'b1);
        wait_n(1);
        check_out("runstep_adv", 8'h01, 1'b1, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);

        // start+stop together in IDLE goes to RUN
        cmd(1'b1, 1'b1, 1'b0);
        check_out("ss_idle_run", 8'h00, 1'b0, 1'b1);

        // Reset mid-RUN with led=0x5A
        cmd(1'b0, 1'b1, 1'b0);
        check_out("rm_pause", 8'h00, 1'b0, 1'b0);
        repeat (90) cmd(1'b0, 1'b0, 1'b1);
        check_out("rm_5a", 8'h5A, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        check_out("rm_run", 8'h5A, 1'b0, 1'b1);
        reset = 1'b1;
        step  = 1'b1;
        @(negedge clock);
        check_out("rm_reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step  = 1'b0;
        @(negedge clock);
        check_out("rm_idle", 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
